// File: rtl/avmm_ccip_cmd_arbiter.sv
// Round-robin arbiter sharing one AVMM->CCI-P command port between two requesters,
// with an in-order route FIFO that steers read responses back to the issuing requester.
module avmm_ccip_cmd_arbiter #(
    parameter int unsigned AVMM_ADDR_WIDTH = 48,
    parameter int unsigned AVMM_DATA_WIDTH = 512,
    parameter int unsigned RD_FIFO_DEPTH   = 64,
    localparam int unsigned CMD_WIDTH      = AVMM_ADDR_WIDTH + AVMM_DATA_WIDTH + 1,
    localparam int unsigned CNT_W          = $clog2(RD_FIFO_DEPTH) + 1
) (
    input  logic                       clk,
    input  logic                       reset_n,

    input  logic [CMD_WIDTH-1:0]       req0_cmd_data,
    input  logic                       req0_cmd_valid,
    output logic                       req0_cmd_ready,
    input  logic [CMD_WIDTH-1:0]       req1_cmd_data,
    input  logic                       req1_cmd_valid,
    output logic                       req1_cmd_ready,

    output logic [CMD_WIDTH-1:0]       cmd_out_data,
    output logic                       cmd_out_valid,
    input  logic                       cmd_out_ready,

    input  logic [AVMM_DATA_WIDTH-1:0] rsp_in_data,
    input  logic                       rsp_in_valid,
    output logic                       rsp_in_ready,

    output logic [AVMM_DATA_WIDTH-1:0] req0_rsp_data,
    output logic                       req0_rsp_valid,
    input  logic                       req0_rsp_ready,
    output logic [AVMM_DATA_WIDTH-1:0] req1_rsp_data,
    output logic                       req1_rsp_valid,
    input  logic                       req1_rsp_ready,

    output logic [CNT_W-1:0]           rd_outstanding,
    output logic                       rsp_underflow
);

    localparam int unsigned PTR_W = $clog2(RD_FIFO_DEPTH);

    logic                 rst_meta_n;
    logic                 rst_sync_n;
    logic                 last_grant;
    logic                 route_mem [RD_FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr;
    logic [PTR_W-1:0]     rd_ptr;
    logic [CNT_W-1:0]     fifo_count;

    logic                 fifo_full_c;
    logic                 fifo_empty_c;
    logic                 load_c;
    logic                 elig0_c;
    logic                 elig1_c;
    logic                 gnt0_c;
    logic                 gnt1_c;
    logic                 accept_c;
    logic [CMD_WIDTH-1:0] sel_data_c;
    logic                 push_c;
    logic                 pop_c;
    logic                 head_id_c;

    // Reset asserts asynchronously, releases two clocks after reset_n rises
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rst_meta_n <= 1'b0;
            rst_sync_n <= 1'b0;
        end else begin
            rst_meta_n <= 1'b1;
            rst_sync_n <= rst_meta_n;
        end
    end

    assign fifo_full_c  = (fifo_count == CNT_W'(RD_FIFO_DEPTH));
    assign fifo_empty_c = (fifo_count == '0);

    // Slot is free when empty or being drained; readies stay low while in reset
    assign load_c  = rst_sync_n & (~cmd_out_valid | cmd_out_ready);
    assign elig0_c = req0_cmd_valid & (~req0_cmd_data[0] | ~fifo_full_c);
    assign elig1_c = req1_cmd_valid & (~req1_cmd_data[0] | ~fifo_full_c);

    always_comb begin
        gnt0_c = 1'b0;
        gnt1_c = 1'b0;
        if (load_c) begin
            if (elig0_c && elig1_c) begin
                gnt0_c = last_grant;
                gnt1_c = ~last_grant;
            end else begin
                gnt0_c = elig0_c;
                gnt1_c = elig1_c;
            end
        end
    end

    assign req0_cmd_ready = gnt0_c;
    assign req1_cmd_ready = gnt1_c;
    assign accept_c       = gnt0_c | gnt1_c;
    assign sel_data_c     = gnt1_c ? req1_cmd_data : req0_cmd_data;
    assign push_c         = accept_c & sel_data_c[0];

    always_ff @(posedge clk or negedge rst_sync_n) begin
        if (!rst_sync_n) begin
            cmd_out_valid <= 1'b0;
            cmd_out_data  <= '0;
            last_grant    <= 1'b1;
        end else if (load_c) begin
            cmd_out_valid <= accept_c;
            if (accept_c) begin
                cmd_out_data <= sel_data_c;
                last_grant   <= gnt1_c;
            end
        end
    end

    // Response steering follows the requester ID at the FIFO head
    assign head_id_c = route_mem[rd_ptr];

    always_comb begin
        req0_rsp_valid = 1'b0;
        req1_rsp_valid = 1'b0;
        rsp_in_ready   = 1'b0;
        if (rst_sync_n) begin
            if (fifo_empty_c) begin
                rsp_in_ready = 1'b1;
            end else if (head_id_c) begin
                req1_rsp_valid = rsp_in_valid;
                rsp_in_ready   = req1_rsp_ready;
            end else begin
                req0_rsp_valid = rsp_in_valid;
                rsp_in_ready   = req0_rsp_ready;
            end
        end
    end

    assign req0_rsp_data = rsp_in_data;
    assign req1_rsp_data = rsp_in_data;
    assign pop_c         = rsp_in_valid & rsp_in_ready & ~fifo_empty_c;

    always_ff @(posedge clk) begin
        if (push_c) begin
            route_mem[wr_ptr] <= gnt1_c;
        end
    end

    always_ff @(posedge clk or negedge rst_sync_n) begin
        if (!rst_sync_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push_c) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop_c) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push_c, pop_c})
                2'b10:   fifo_count <= fifo_count + CNT_W'(1);
                2'b01:   fifo_count <= fifo_count - CNT_W'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // A response with nothing outstanding is dropped and flagged until reset
    always_ff @(posedge clk or negedge rst_sync_n) begin
        if (!rst_sync_n) begin
            rsp_underflow <= 1'b0;
        end else if (rsp_in_valid && rsp_in_ready && fifo_empty_c) begin
            rsp_underflow <= 1'b1;
        end
    end

    assign rd_outstanding = fifo_count;

endmodule

// File: tb/tb_avmm_ccip_cmd_arbiter.sv
// Directed bench for avmm_ccip_cmd_arbiter: reset, fairness, backpressure,
// response routing, route-FIFO full and response stall / underflow.
module tb_avmm_ccip_cmd_arbiter;

    localparam int unsigned AW    = 48;
    localparam int unsigned DW    = 512;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned CW    = AW + DW + 1;
    localparam int unsigned CNTW  = $clog2(DEPTH) + 1;

    logic            clk = 1'b0;
    logic            reset_n;
    logic [CW-1:0]   req0_cmd_data, req1_cmd_data, cmd_out_data;
    logic            req0_cmd_valid, req0_cmd_ready, req1_cmd_valid, req1_cmd_ready;
    logic            cmd_out_valid, cmd_out_ready;
    logic [DW-1:0]   rsp_in_data, req0_rsp_data, req1_rsp_data;
    logic            rsp_in_valid, rsp_in_ready;
    logic            req0_rsp_valid, req0_rsp_ready, req1_rsp_valid, req1_rsp_ready;
    logic [CNTW-1:0] rd_outstanding;
    logic            rsp_underflow;

    int n_cmp = 0;
    int n_mis = 0;

    avmm_ccip_cmd_arbiter #(
        .AVMM_ADDR_WIDTH (AW),
        .AVMM_DATA_WIDTH (DW),
        .RD_FIFO_DEPTH   (DEPTH)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .req0_cmd_data  (req0_cmd_data),
        .req0_cmd_valid (req0_cmd_valid),
        .req0_cmd_ready (req0_cmd_ready),
        .req1_cmd_data  (req1_cmd_data),
        .req1_cmd_valid (req1_cmd_valid),
        .req1_cmd_ready (req1_cmd_ready),
        .cmd_out_data   (cmd_out_data),
        .cmd_out_valid  (cmd_out_valid),
        .cmd_out_ready  (cmd_out_ready),
        .rsp_in_data    (rsp_in_data),
        .rsp_in_valid   (rsp_in_valid),
        .rsp_in_ready   (rsp_in_ready),
        .req0_rsp_data  (req0_rsp_data),
        .req0_rsp_valid (req0_rsp_valid),
        .req0_rsp_ready (req0_rsp_ready),
        .req1_rsp_data  (req1_rsp_data),
        .req1_rsp_valid (req1_rsp_valid),
        .req1_rsp_ready (req1_rsp_ready),
        .rd_outstanding (rd_outstanding),
        .rsp_underflow  (rsp_underflow)
    );

    always #5 clk = ~clk;

    function automatic logic [CW-1:0] mk(input int r, input int i, input bit rd);
        return {AW'(r * 4096 + i), DW'(32'hD000_0000 + r * 256 + i), rd};
    endfunction

    function automatic logic [DW-1:0] rsp(input int n);
        return DW'(64'hABCD_0000_0000 + n);
    endfunction

    task automatic check(input string tag, input logic [CW-1:0] obs, input logic [CW-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int i0;
        int i1;
        reset_n        = 1'b1;
        req0_cmd_data  = '0;
        req1_cmd_data  = '0;
        req0_cmd_valid = 1'b0;
        req1_cmd_valid = 1'b0;
        cmd_out_ready  = 1'b1;
        rsp_in_data    = '0;
        rsp_in_valid   = 1'b0;
        req0_rsp_ready = 1'b1;
        req1_rsp_ready = 1'b1;
        repeat (3) @(negedge clk);

        // Reset asserted with a valid request pending
        @(negedge clk); reset_n = 1'b0; req0_cmd_valid = 1'b1; req0_cmd_data = mk(0, 99, 0); #1;
        check("rst_cmd_valid", cmd_out_valid, 0);
        check("rst_cmd_data", cmd_out_data, 0);
        check("rst_outstanding", rd_outstanding, 0);
        check("rst_rdy0", req0_cmd_ready, 0);
        check("rst_underflow", rsp_underflow, 0);
        @(negedge clk); reset_n = 1'b1; req0_cmd_valid = 1'b0; #1;
        @(negedge clk);

        // Fairness: both stream writes, alternate 0,1,0,1 at one per cycle
        i0 = 0;
        i1 = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            req0_cmd_valid = 1'b1; req1_cmd_valid = 1'b1;
            req0_cmd_data = mk(0, i0, 0); req1_cmd_data = mk(1, i1, 0);
            #1;
            check("rr_rdy0", req0_cmd_ready, (k % 2) == 0);
            check("rr_rdy1", req1_cmd_ready, (k % 2) == 1);
            if (k > 0) begin
                check("rr_out_valid", cmd_out_valid, 1);
                check("rr_out_data", cmd_out_data, mk((k - 1) % 2, (k - 1) / 2, 0));
            end
            if ((k % 2) == 0) i0++; else i1++;
        end

        // Backpressure: output held, nobody accepted
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            cmd_out_ready = 1'b0;
            req0_cmd_data = mk(0, 3, 0); req1_cmd_data = mk(1, 3, 0);
            #1;
            check("bp_rdy0", req0_cmd_ready, 0);
            check("bp_rdy1", req1_cmd_ready, 0);
            check("bp_hold_data", cmd_out_data, mk(1, 2, 0));
            check("bp_hold_valid", cmd_out_valid, 1);
        end
        @(negedge clk); cmd_out_ready = 1'b1; #1;
        check("bp_resume_rdy0", req0_cmd_ready, 1);
        check("bp_resume_rdy1", req1_cmd_ready, 0);
        @(negedge clk); req0_cmd_data = mk(0, 4, 0); #1;
        check("bp_next0", cmd_out_data, mk(0, 3, 0));
        check("bp_rdy1_turn", req1_cmd_ready, 1);
        @(negedge clk); req0_cmd_valid = 1'b0; req1_cmd_valid = 1'b0; #1;
        check("bp_next1", cmd_out_data, mk(1, 3, 0));
        @(negedge clk); #1;
        check("idle_valid", cmd_out_valid, 0);

        // Routing: reads 0,1,0 then three in-order responses
        @(negedge clk); req0_cmd_valid = 1'b1; req0_cmd_data = mk(0, 0, 1); #1;
        check("rt_rdy0_a", req0_cmd_ready, 1);
        @(negedge clk); req0_cmd_valid = 1'b0; req1_cmd_valid = 1'b1; req1_cmd_data = mk(1, 0, 1); #1;
        check("rt_rdy1_b", req1_cmd_ready, 1);
        check("rt_out_1", rd_outstanding, 1);
        @(negedge clk); req1_cmd_valid = 1'b0; req0_cmd_valid = 1'b1; req0_cmd_data = mk(0, 1, 1); #1;
        check("rt_rdy0_c", req0_cmd_ready, 1);
        check("rt_out_2", rd_outstanding, 2);
        @(negedge clk); req0_cmd_valid = 1'b0; rsp_in_valid = 1'b1; rsp_in_data = rsp(0); #1;
        check("rt_out_3", rd_outstanding, 3);
        check("rt_cmd_c", cmd_out_data, mk(0, 1, 1));
        check("rt_d0_v0", req0_rsp_valid, 1);
        check("rt_d0_v1", req1_rsp_valid, 0);
        check("rt_d0_data", req0_rsp_data, rsp(0));
        check("rt_d0_ready", rsp_in_ready, 1);
        @(negedge clk); rsp_in_data = rsp(1); #1;
        check("rt_d1_v1", req1_rsp_valid, 1);
        check("rt_d1_v0", req0_rsp_valid, 0);
        check("rt_d1_data", req1_rsp_data, rsp(1));
        check("rt_out_after_d0", rd_outstanding, 2);
        @(negedge clk); rsp_in_data = rsp(2); #1;
        check("rt_d2_v0", req0_rsp_valid, 1);
        check("rt_d2_v1", req1_rsp_valid, 0);
        check("rt_out_after_d1", rd_outstanding, 1);
        @(negedge clk); rsp_in_valid = 1'b0; #1;
        check("rt_out_0", rd_outstanding, 0);
        check("rt_no_underflow", rsp_underflow, 0);

        // Full route FIFO: fifth read stalls, writes still pass
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); req0_cmd_valid = 1'b1; req0_cmd_data = mk(0, 10 + i, 1); #1;
            check("full_fill_rdy0", req0_cmd_ready, 1);
        end
        @(negedge clk); req0_cmd_data = mk(0, 14, 1); req1_cmd_valid = 1'b1; req1_cmd_data = mk(1, 20, 0); #1;
        check("full_out_4", rd_outstanding, 4);
        check("full_rd_stall", req0_cmd_ready, 0);
        check("full_wr_pass", req1_cmd_ready, 1);
        @(negedge clk); req1_cmd_valid = 1'b0; rsp_in_valid = 1'b1; rsp_in_data = rsp(3); #1;
        check("full_wr_out", cmd_out_data, mk(1, 20, 0));
        check("full_prepop_stall", req0_cmd_ready, 0);
        check("full_rsp_v0", req0_rsp_valid, 1);
        @(negedge clk); rsp_in_valid = 1'b0; #1;
        check("full_out_3", rd_outstanding, 3);
        check("full_rd_accept", req0_cmd_ready, 1);
        @(negedge clk); req0_cmd_valid = 1'b0; #1;
        check("full_rd5_out", cmd_out_data, mk(0, 14, 1));
        check("full_out_4b", rd_outstanding, 4);

        // Drain, then response stall and underflow
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); rsp_in_valid = 1'b1; rsp_in_data = rsp(4 + i); #1;
            check("drain_v0", req0_rsp_valid, 1);
        end
        @(negedge clk); rsp_in_valid = 1'b0; req1_cmd_valid = 1'b1; req1_cmd_data = mk(1, 30, 1); #1;
        check("drain_out_0", rd_outstanding, 0);
        check("st_rdy1", req1_cmd_ready, 1);
        @(negedge clk); req1_cmd_valid = 1'b0; req1_rsp_ready = 1'b0; rsp_in_valid = 1'b1; rsp_in_data = rsp(8); #1;
        check("st_out_1", rd_outstanding, 1);
        check("st_v1", req1_rsp_valid, 1);
        check("st_in_ready0", rsp_in_ready, 0);
        @(negedge clk); #1;
        check("st_hold_out", rd_outstanding, 1);
        check("st_hold_ready", rsp_in_ready, 0);
        @(negedge clk); req1_rsp_ready = 1'b1; #1;
        check("st_release", rsp_in_ready, 1);
        @(negedge clk); rsp_in_data = rsp(9); #1;
        check("uf_out_0", rd_outstanding, 0);
        check("uf_in_ready", rsp_in_ready, 1);
        check("uf_v0", req0_rsp_valid, 0);
        check("uf_v1", req1_rsp_valid, 0);
        check("uf_flag_pre", rsp_underflow, 0);
        @(negedge clk); rsp_in_valid = 1'b0; #1;
        check("uf_flag_set", rsp_underflow, 1);
        @(negedge clk); #1;
        check("uf_flag_sticky", rsp_underflow, 1);
        check("uf_out_stays", rd_outstanding, 0);

        // Reset in the middle of traffic
        @(negedge clk);
        req0_cmd_valid = 1'b1; req0_cmd_data = mk(0, 40, 1);
        req1_cmd_valid = 1'b1; req1_cmd_data = mk(1, 41, 0);
        #1;
        check("mid_rdy0", req0_cmd_ready, 1);
        @(negedge clk); #1;
        check("mid_out_1", rd_outstanding, 1);
        check("mid_valid", cmd_out_valid, 1);
        check("mid_rdy1", req1_cmd_ready, 1);
        reset_n = 1'b0; #1;
        check("mid_rst_valid", cmd_out_valid, 0);
        check("mid_rst_out", rd_outstanding, 0);
        check("mid_rst_rdy0", req0_cmd_ready, 0);
        check("mid_rst_rdy1", req1_cmd_ready, 0);
        check("mid_rst_uf", rsp_underflow, 0);
        @(negedge clk); reset_n = 1'b1; #1;
        check("rel_rdy0_a", req0_cmd_ready, 0);
        @(negedge clk); #1;
        check("rel_rdy0_b", req0_cmd_ready, 0);
        @(negedge clk); #1;
        check("rel_rdy0_c", req0_cmd_ready, 1);
        check("rel_rdy1_c", req1_cmd_ready, 0);
        check("rel_out", rd_outstanding, 0);
        @(negedge clk); req0_cmd_valid = 1'b0; req1_cmd_valid = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
